// File: rtl/pad_responder_pkg.sv
// Constants shared by the pad responder, the pad receiver and the input collector:
// button bit positions, frame lengths, FSM encoding and the frame-word builder.
package pad_responder_pkg;

   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;
   localparam int BTN_Y      = 8;
   localparam int BTN_X      = 9;
   localparam int BTN_L      = 10;
   localparam int BTN_R      = 11;

   localparam int NES_FRAME_BITS  = 8;
   localparam int SNES_FRAME_BITS = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LATCH = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } pad_state_t;

   // Serial word, bit 0 first on the wire; pad lines are active low.
   function automatic logic [15:0] build_frame(input logic [11:0] b, input logic snes);
      logic [15:0] w;
      if (snes)
         w = {4'hF, ~b[BTN_R], ~b[BTN_L], ~b[BTN_X], ~b[BTN_A],
              ~b[BTN_RIGHT], ~b[BTN_LEFT], ~b[BTN_DOWN], ~b[BTN_UP],
              ~b[BTN_START], ~b[BTN_SELECT], ~b[BTN_Y], ~b[BTN_B]};
      else
         w = {8'h00, ~b[BTN_RIGHT], ~b[BTN_LEFT], ~b[BTN_DOWN], ~b[BTN_UP],
              ~b[BTN_START], ~b[BTN_SELECT], ~b[BTN_B], ~b[BTN_A]};
      return w;
   endfunction

   function automatic logic [4:0] frame_len(input logic snes);
      return snes ? 5'(SNES_FRAME_BITS) : 5'(NES_FRAME_BITS);
   endfunction

endpackage

// File: rtl/pad_responder_sync_edge.sv
// Multi-flop synchroniser for one asynchronous host line, plus a delay flop
// producing single-cycle rise/fall pulses in the clk domain.
module pad_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   dly_q;

   // Reset value matches the line's idle level so no edge appears after reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
         dly_q  <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         dly_q  <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;
   assign fall = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/pad_responder.sv
// Device side of the NES/SNES serial pad protocol: captures buttons on latch,
// shifts them out on pad_clk. Optional stall recovery with PAD_RESP_TIMEOUT_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no frame; pad_data high, busy low
// ST_LATCH | frame captured, latch still high; pad_clk ignored
// ST_SHIFT | each pad_clk rise advances one bit
// ST_DONE  | frame complete; pad_data low until the next latch rise
module pad_responder
   import pad_responder_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 25000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pad_latch,
   input  logic        pad_clk,
   input  logic        snes_mode,
   input  logic [11:0] buttons,
   output logic        pad_data,
   output logic        busy,
   output logic [4:0]  bit_index,
   output logic        frame_done
);

   if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("pad_responder: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
   end

   logic latch_rise, latch_fall, clk_rise, clk_fall;

   pad_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_latch_sync (
      .clk(clk), .rst_n(rst_n), .async_in(pad_latch), .rise(latch_rise), .fall(latch_fall)
   );

   pad_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_clk_sync (
      .clk(clk), .rst_n(rst_n), .async_in(pad_clk), .rise(clk_rise), .fall(clk_fall)
   );

   pad_state_t  state_q, state_d;
   logic [15:0] shreg_q, shreg_d;
   logic        snes_q, snes_d;
   logic [4:0]  idx_q, idx_d;
   logic        done_q, done_d;
   logic        tmo_hit;

`ifdef PAD_RESP_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TMO_W-1:0] tmo_cnt_q;
   logic             host_edge;

   assign host_edge = latch_rise | latch_fall | clk_rise | clk_fall;

   always_ff @(posedge clk) begin
      if (!rst_n)
         tmo_cnt_q <= TMO_W'(TIMEOUT_CYCLES - 1);
      else if (host_edge)
         tmo_cnt_q <= TMO_W'(TIMEOUT_CYCLES - 1);
      else if (tmo_cnt_q != '0)
         tmo_cnt_q <= tmo_cnt_q - 1'b1;
   end

   assign tmo_hit = (tmo_cnt_q == '0) && !host_edge &&
                    (state_q == ST_LATCH || state_q == ST_SHIFT);
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         shreg_q <= '1;
         snes_q  <= 1'b0;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         snes_q  <= snes_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

   // Latch rise outranks everything, including a coincident pad_clk edge.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      snes_d  = snes_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      if (latch_rise) begin
         state_d = ST_LATCH;
         shreg_d = build_frame(buttons, snes_mode);
         snes_d  = snes_mode;
         idx_d   = '0;
      end else if (tmo_hit) begin
         state_d = ST_IDLE;
         idx_d   = '0;
      end else begin
         case (state_q)
            ST_LATCH: if (latch_fall) state_d = ST_SHIFT;
            ST_SHIFT: begin
               if (clk_rise) begin
                  shreg_d = {1'b0, shreg_q[15:1]};
                  idx_d   = idx_q + 5'd1;
                  if (idx_d == frame_len(snes_q)) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      pad_data = 1'b1;
      busy     = 1'b0;
      case (state_q)
         ST_LATCH, ST_SHIFT: begin
            pad_data = shreg_q[0];
            busy     = 1'b1;
         end
         ST_DONE: pad_data = 1'b0;
         default: ;
      endcase
   end

   assign bit_index  = idx_q;
   assign frame_done = done_q;

endmodule

// File: doc/pad_responder.md
Name: pad_responder

Overview:
- Device-side end of the NES/SNES serial pad protocol: the block takes latch and pulse-clock lines from a host and shifts button states out on the data line.
- Used as an on-chip virtual controller for hardware-in-loop bring-up of the controller receiver, and as a bench driver. Buttons come from uio_in or a test register.
- Purely synchronous to clk. External latch and pulse-clock lines are asynchronous and are synchronised internally.

Parameters:
- SYNC_STAGES, 2, synchroniser flop count on pad_latch and pad_clk (minimum 2).
- TIMEOUT_CYCLES, 25000, idle-abort limit in clk cycles; used only with PAD_RESP_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, 25 MHz.
- rst_n  in  1  synchronous, active-low reset.
- pad_latch  in  1  host latch, asynchronous, active high.
- pad_clk  in  1  host pulse clock, asynchronous, idle high.
- snes_mode  in  1  1 = 16-bit SNES frame, 0 = 8-bit NES frame. Sampled at latch.
- buttons  in  12  pressed = 1. Bit order {R,L,X,Y,Right,Left,Down,Up,Start,Select,B,A}.
- pad_data  out  1  serial data, active low (0 = pressed).
- busy  out  1  high from latch capture until the frame completes.
- bit_index  out  5  index of the bit currently driven on pad_data (0..16).
- frame_done  out  1  one-cycle pulse when the last bit has been shifted out.

Behaviour:
- Sync and edges: each of pad_latch and pad_clk passes through SYNC_STAGES flops, then a delay flop for edge detection. Latency from an external edge to the pad_data update is SYNC_STAGES+1 clk (3 at default).
- Frame word, built at capture:
  - SNES: {1,1,1,1, ~R,~L,~X,~A, ~Right,~Left,~Down,~Up, ~Start,~Select,~Y,~B}; bit 0 goes out first. Bits 12-15 are forced high (unpressed ID bits).
  - NES: {~Right,~Left,~Down,~Up,~Start,~Select,~B,~A} in bits 7..0; bit 0 (A) goes out first.
- FSM states: IDLE, LATCH, SHIFT, DONE.
  - IDLE: pad_data=1, busy=0, bit_index=0.
  - Latch rising edge, from any state: load the 16-bit shift register, capture snes_mode, go to LATCH. pad_data = bit0, bit_index=0, busy=1.
  - LATCH: while latch is high, pad_clk edges are ignored and buttons are held. Latch falling edge -> SHIFT.
  - SHIFT: each pad_clk rising edge shifts right by 1 (shifting in 0) and increments bit_index. pad_data always equals shreg[0].
    - When bit_index reaches 8 (NES) or 16 (SNES): frame_done=1 for one cycle, go to DONE.
  - DONE: pad_data=0, the standard post-frame level (reads as 1 on the host). Further pad_clk edges are ignored and bit_index saturates at 8 or 16. busy=0. Stays until the next latch rise.
- Boundary conditions:
  - Latch rise during SHIFT: abort, recapture, restart at bit 0. No frame_done is emitted.
  - Latch and pad_clk edges in the same cycle: latch wins and the clock edge is discarded.
  - Button changes after capture do not affect the current frame.
  - snes_mode change mid-frame: ignored until the next capture.
- Reset, including mid-frame: IDLE, pad_data=1, busy=0, bit_index=0, frame_done=0. Synchroniser flops reset to 1 for pad_clk and 0 for pad_latch, so no false edge follows reset.

Optional Feature:
- Macro PAD_RESP_TIMEOUT_EN.
- Defined:
  - An idle counter clears on every latch or pad_clk edge.
  - In LATCH or SHIFT, if it reaches TIMEOUT_CYCLES, go to IDLE: pad_data=1, busy=0, no frame_done.
  - This recovers from a host that stalls mid-frame.
- Undefined: no counter. The FSM waits indefinitely, and TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package:
  - Button bit-position constants: BTN_A=0 .. BTN_R=11.
  - NES_FRAME_BITS=8, SNES_FRAME_BITS=16.
  - State encoding for IDLE/LATCH/SHIFT/DONE.
  - These constants are shared with the receiver and input collector.
- One natural sub-module: pad_sync_edge. It contains the parameterised synchroniser plus rise/fall pulse outputs and is instantiated twice.

Test Plan:
- NES, buttons=12'h001 (A), latch 12 µs, then 8 clocks of 6 µs half-period -> pad_data sequence 0,1,1,1,1,1,1,1; then 0 after bit 8; frame_done pulses once.
- SNES, buttons=12'h802 (R,B) -> 16 bits: 0,1,1,1,1,1,1,1,1,1,1,0,1,1,1,1; bit_index ends at 16; busy falls with frame_done.
- Latch re-asserted after 5 SNES clocks, with buttons changed to 12'h010 (Up) -> bit_index returns to 0, no frame_done, new frame shows Up at bit 4.
- Latch and pad_clk edges coincident in the same clk cycle -> bit_index stays 0, pad_data = captured bit 0.
- rst_n low for 1 cycle at bit 6 of a frame -> pad_data=1, busy=0, bit_index=0 next cycle; the following pad_clk edge causes no shift.
- With PAD_RESP_TIMEOUT_EN, TIMEOUT_CYCLES=100: latch, then 3 clocks, then stall -> IDLE after 100 cycles, pad_data=1, no frame_done.
